// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program image into imem, then holds the core in reset for a settle window.
// Optional trailing checksum word check is enabled with `define BOOT_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH),
    parameter int RESET_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              load_done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam int HOLD_W = $clog2(RESET_HOLD + 1);
    // Counter runs RESET_HOLD-1 .. 0 so core_rst falls exactly RESET_HOLD cycles after the last write.
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);
    localparam logic [ADDR_W:0]   TOP_ADDR  = (ADDR_W + 1)'(IMEM_DEPTH - 1);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {LOAD, CHECK, HOLD, RUN, ERROR} state_t;
    logic [31:0] csum;
`else
    typedef enum logic [2:0] {LOAD, HOLD, RUN, ERROR} state_t;
`endif

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hs;
    logic              at_top;

    assign hs     = s_valid & s_ready;
    assign at_top = (word_count == TOP_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            core_rst   <= 1'b1;
            load_done  <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
            hold_cnt   <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                LOAD: begin
                    s_ready <= 1'b1;
                    if (hs) begin
                        imem_we    <= 1'b1;
                        imem_waddr <= word_count[ADDR_W-1:0];
                        imem_wdata <= s_data;
                        word_count <= word_count + 1'b1;
`ifdef BOOT_CHECKSUM_EN
                        csum       <= csum + s_data;
`endif
                        if (s_last) begin
`ifdef BOOT_CHECKSUM_EN
                            state    <= CHECK;
`else
                            state    <= HOLD;
                            s_ready  <= 1'b0;
                            hold_cnt <= HOLD_INIT;
`endif
                        end else if (at_top) begin
                            // Image is larger than imem: last slot still written, then fault.
                            state   <= ERROR;
                            s_ready <= 1'b0;
                            error   <= 1'b1;
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CHECK: begin
                    if (hs) begin
                        s_ready <= 1'b0;
                        if (csum + s_data == 32'd0) begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_INIT;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state     <= RUN;
                        core_rst  <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                RUN:     ;
                ERROR:   ;
                default: state <= ERROR;
            endcase
        end
    end

endmodule
